ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It is the sending counterpart of the existing PS2_keyboard receiver. It sends command bytes to the keyboard, for example 0xFF reset, 0xED set-LEDs or 0xF4 enable. It drives the open-drain ps2_clk/ps2_data lines through output-enable pulls and follows the standard inhibit / request-to-send / device-clocked framing, including the device ACK. It sits beside PS2_keyboard in Top; the top level builds the tristates from its *_oe outputs.

---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_line_sync.sv | 54 +++++
 rtl/ps2_host_tx.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host-side logic: transmitter state
// encoding, common keyboard command bytes, the device acknowledge byte and
// the parity helper used when a byte is latched for sending.
// ----------------------------------------------------------------------------
package ps2_pkg;

    // Host transmitter states.
    //   IDLE      : lines released, waiting for a byte
    //   INHIBIT   : host holds ps2_clk low to stop the device
    //   RTS       : clock released, start bit (data low) asserted
    //   DATA      : device-clocked shift of d0..d7, parity, stop
    //   ACK       : waiting for the device to pull data low on the 11th clock
    //   WAIT_IDLE : waiting for both lines to return high
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        DATA      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_t;

    // Keyboard commands commonly sent by the host.
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;

    // Byte the keyboard returns after accepting a command.
    localparam logic [7:0] ACK_BYTE    = 8'hFA;

    // PS/2 frames carry odd parity: the parity bit makes the total count of
    // ones across data + parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ----------------------------------------------------------------------------
// ps2_line_sync
// Conditions one raw PS/2 pad level for use in the clk domain: a 2-FF
// synchronizer followed by a glitch filter that only accepts a new level
// after FILTER_LEN consecutive identical synchronized samples. Also emits a
// one-cycle strobe when the filtered level goes from 1 to 0.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   pad    in   raw asynchronous pad level
//   level  out  synchronized, filtered level (resets to 1, the idle bus level)
//   fall   out  one-cycle strobe, filtered level went 1 -> 0
// ----------------------------------------------------------------------------
module ps2_line_sync #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;

    // cnt counts consecutive samples that disagree with the current level;
    // any agreeing sample restarts the run, so short glitches never land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            cnt    <= '0;
            level  <= 1'b1;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pad};
            fall   <= 1'b0;
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync_q[1];
                // New level is ~level here, so a 1 -> 0 move is old level 1.
                fall  <= level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter. Sends one command byte to the keyboard
// using inhibit / request-to-send / device-clocked framing and checks the
// device acknowledge bit. The open-drain lines are controlled through
// output-enable pulls; the top level builds the tristates.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   tx_data      in   byte to send, captured on accept
//   tx_valid     in   request to send tx_data
//   tx_ready     out  high in IDLE only; accept = tx_valid & tx_ready
//   tx_busy      out  accept through the done/err pulse cycle
//   tx_done      out  one-cycle pulse: frame sent, ACK seen, bus idle
//   tx_err       out  one-cycle pulse: timeout or missing ACK
//   ps2_clk_in   in   raw ps2_clk pad level
//   ps2_data_in  in   raw ps2_data pad level
//   ps2_clk_oe   out  1 = pull ps2_clk low
//   ps2_data_oe  out  1 = pull ps2_data low
// ----------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_t    state;
    logic [8:0]    shreg;     // {parity, data}, shifted out LSB first
    logic [3:0]    bit_cnt;   // device falls seen in this frame
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] tout_cnt;

    logic clk_level;
    logic clk_fall;
    logic data_level;
    logic unused_data_fall;   // the transmitter never needs data edges

    logic accept;
    logic timeout;

    assign accept  = tx_valid & tx_ready;
    assign timeout = (tout_cnt == TW'(TIMEOUT_CYCLES - 1));

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
        .clk   (clk),
        .rst   (rst),
        .pad   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    // Data is only sampled on filtered clock falls, which already lag the
    // pad by the clock filter, so a single-sample filter is enough here.
    ps2_line_sync #(.FILTER_LEN(1)) u_data_sync (
        .clk   (clk),
        .rst   (rst),
        .pad   (ps2_data_in),
        .level (data_level),
        .fall  (unused_data_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tx_ready    <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            tout_cnt    <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;

            case (state)
                // Ready/busy update here, one cycle after any pulse, so busy
                // covers the pulse cycle and a new accept cannot overlap it.
                IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_busy     <= 1'b0;
                    tx_ready    <= 1'b1;
                    if (accept) begin
                        shreg      <= {odd_parity(tx_data), tx_data};
                        bit_cnt    <= '0;
                        inh_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        tx_ready   <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= INHIBIT;
                    end
                end

                // Host owns the clock; any device edges are ignored.
                INHIBIT: begin
                    if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;   // start bit
                        tout_cnt    <= '0;
                        state       <= RTS;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end

                // First device fall: present d0.
                RTS: begin
                    if (clk_fall) begin
                        ps2_data_oe <= ~shreg[0];
                        shreg       <= shreg >> 1;
                        bit_cnt     <= 4'd1;
                        tout_cnt    <= '0;
                        state       <= DATA;
                    end else if (timeout) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tout_cnt <= tout_cnt + 1'b1;
                    end
                end

                // Falls 2..9 present d1..d7 then parity; fall 10 releases
                // data so the device samples a stop bit of 1.
                DATA: begin
                    if (clk_fall) begin
                        tout_cnt <= '0;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd9) begin
                            ps2_data_oe <= 1'b0;
                            state       <= ACK;
                        end else begin
                            ps2_data_oe <= ~shreg[0];
                            shreg       <= shreg >> 1;
                        end
                    end else if (timeout) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tout_cnt <= tout_cnt + 1'b1;
                    end
                end

                // Device pulls data low across the 11th clock to acknowledge.
                ACK: begin
                    if (clk_fall) begin
                        tout_cnt <= '0;
                        if (!data_level) begin
                            state <= WAIT_IDLE;
                        end else begin
                            tx_err <= 1'b1;
                            state  <= IDLE;
                        end
                    end else if (timeout) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tout_cnt <= tout_cnt + 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    if (clk_level && data_level) begin
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end else if (timeout) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tout_cnt <= tout_cnt + 1'b1;
                    end
                end

                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_host_tx
// Drives ps2_host_tx against a PS/2 device model (40-cycle clock period,
// samples data on rising edges, drives the ACK). Expected done/err events
// and expected received frames are queued when a byte is issued; a monitor
// pops events on every done/err pulse and the device model pops frames
// when it finishes capturing.
// ----------------------------------------------------------------------------
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 20;
    localparam int TMO  = 400;
    localparam int FLT  = 2;
    localparam int HALF = 20;

    localparam int M_NORMAL = 0;
    localparam int M_NOACK  = 1;
    localparam int M_STOP5  = 2;
    localparam int M_RST6   = 3;
    localparam int M_GLITCH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0;

    // Open-drain wired-AND of host pulls and device drive.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe & ~glitch;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    int nvec = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic  is_err;
        string tag;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        string      tag;
    } fr_t;

    ev_t ev_q[$];
    fr_t fr_q[$];

    // Event monitor: every done/err pulse must match the next expected event.
    always @(negedge clk) begin
        if (!rst && (tx_done || tx_err)) begin
            if (ev_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, tx_done, tx_err}, 32'd0);
            end else begin
                ev_t e;
                e = ev_q.pop_front();
                chk({e.tag, "_pulse_kind"}, {30'd0, tx_done, tx_err},
                    e.is_err ? 32'd1 : 32'd2);
            end
        end
    end

    // Inhibit monitor: every clk_oe run lasts INH cycles and the start bit
    // is asserted in the same cycle the clock is released.
    int   inh_len = 0;
    logic prev_clk_oe = 1'b0;
    always @(negedge clk) begin
        if (ps2_clk_oe) begin
            inh_len++;
        end else if (prev_clk_oe) begin
            chk("inhibit_len", inh_len, INH);
            chk("start_at_release", {31'd0, ps2_data_oe}, 32'd1);
            inh_len = 0;
        end
        prev_clk_oe = ps2_clk_oe;
    end

    // Called at a negedge with tx_valid already high.
    task automatic do_accept(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_ready_seen"}, {31'd0, ok}, 32'd1);
        @(negedge clk);
        chk({tag, "_accepted"}, {29'd0, tx_ready, tx_busy, ps2_clk_oe}, 32'b011);
    endtask

    // Waits for the done/err pulse, then checks the cycle after it.
    task automatic wait_end(input string tag, output int pcyc);
        pcyc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (tx_done || tx_err) break;
        end
        chk({tag, "_pulse_seen"}, {31'd0, tx_done | tx_err}, 32'd1);
        if (!(tx_done || tx_err)) return;
        pcyc = cyc;
        chk({tag, "_busy_in_pulse"}, {30'd0, tx_busy, tx_ready}, 32'b10);
        @(negedge clk);
        chk({tag, "_after_pulse"},
            {28'd0, tx_ready, tx_busy, ps2_clk_oe, ps2_data_oe}, 32'b1000);
    endtask

    // Device model: detects request-to-send, generates up to 11 clocks,
    // samples on rising edges and optionally drives the ACK.
    task automatic dev_frame(input int mode, input string tag, output int last_fall);
        logic [9:0] bits;
        logic       start;
        bit         got;
        fr_t        fr;
        bits      = '0;
        last_fall = -1;
        got       = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe && ps2_data_oe) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_rts_seen"}, {31'd0, got}, 32'd1);
        if (!got) return;
        repeat (HALF) @(negedge clk);
        start = ps2_data_in;
        for (int f = 1; f <= 11; f++) begin
            if (mode == M_STOP5 && f == 6) break;
            if (f == 11 && mode != M_NOACK) begin
                dev_data = 1'b0;
                repeat (2) @(negedge clk);
            end
            dev_clk   = 1'b0;
            last_fall = cyc;
            if (mode == M_RST6 && f == 6) begin
                rst = 1'b1;
                #1;
                chk("rst_mid_frame",
                    {29'd0, ps2_clk_oe, ps2_data_oe, tx_busy}, 32'd0);
                repeat (2) @(negedge clk);
                rst     = 1'b0;
                dev_clk = 1'b1;
                return;
            end
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (f <= 10) bits[f-1] = ps2_data_in;
            if (f == 11) dev_data = 1'b1;
            if (mode == M_GLITCH && f == 4) begin
                repeat (HALF / 2) @(negedge clk);
                glitch = 1'b1;
                @(negedge clk);
                glitch = 1'b0;
                repeat (HALF / 2 - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        if (mode == M_STOP5) return;
        chk({tag, "_frame_expected"}, {31'd0, fr_q.size() != 0}, 32'd1);
        if (fr_q.size() == 0) return;
        fr = fr_q.pop_front();
        chk({fr.tag, "_start"}, {31'd0, start}, 32'd0);
        chk({fr.tag, "_data"}, {24'd0, bits[7:0]}, {24'd0, fr.data});
        chk({fr.tag, "_parity"}, {31'd0, bits[8]}, {31'd0, fr.par});
        chk({fr.tag, "_stop"}, {31'd0, bits[9]}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, nvec=%0d", nvec);
        $fatal(1, "watchdog");
    end

    initial begin
        int lf, pc, early;

        // Reset
        repeat (3) @(negedge clk);
        chk("reset_state_in_rst",
            {26'd0, tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}, 32'b100000);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state",
            {26'd0, tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}, 32'b100000);

        // 1. 0xF4: bits 0,0,1,0,1,1,1,1, parity 0
        ev_q.push_back('{1'b0, "f4"});
        fr_q.push_back('{8'hF4, 1'b0, "f4"});
        tx_data = CMD_ENABLE; tx_valid = 1'b1;
        do_accept("f4");
        tx_valid = 1'b0;
        fork
            dev_frame(M_NORMAL, "f4", lf);
            wait_end("f4", pc);
        join
        repeat (5) @(negedge clk);

        // 2. 0xED then 0x00 with tx_valid held: both parity 1
        ev_q.push_back('{1'b0, "ed"});
        fr_q.push_back('{8'hED, 1'b1, "ed"});
        tx_data = CMD_SET_LED; tx_valid = 1'b1;
        do_accept("ed");
        ev_q.push_back('{1'b0, "zero"});
        fr_q.push_back('{8'h00, 1'b1, "zero"});
        tx_data = 8'h00;
        early = 0;
        fork
            dev_frame(M_NORMAL, "ed", lf);
            begin
                for (int i = 0; i < 3000; i++) begin
                    if (tx_done || tx_err) break;
                    if (tx_ready) early++;
                    @(negedge clk);
                end
                chk("b2b_first_pulse", {31'd0, tx_done}, 32'd1);
                chk("b2b_no_early_ready", early, 0);
                @(negedge clk);
                chk("b2b_ready_after_pulse", {31'd0, tx_ready}, 32'd1);
            end
        join
        @(negedge clk);
        chk("b2b_second_accepted", {29'd0, tx_ready, tx_busy, ps2_clk_oe}, 32'b011);
        tx_valid = 1'b0;
        fork
            dev_frame(M_NORMAL, "zero", lf);
            wait_end("zero", pc);
        join
        repeat (5) @(negedge clk);

        // 3. Missing ACK: 0x01, parity 0
        ev_q.push_back('{1'b1, "noack"});
        fr_q.push_back('{8'h01, 1'b0, "noack"});
        tx_data = 8'h01; tx_valid = 1'b1;
        do_accept("noack");
        tx_valid = 1'b0;
        fork
            dev_frame(M_NOACK, "noack", lf);
            wait_end("noack", pc);
        join
        repeat (5) @(negedge clk);

        // 4. Device stops after fall 5. Pad fall -> 2 sync flops -> FLT
        //    filter samples -> FSM registers the fall, then TMO cycles.
        ev_q.push_back('{1'b1, "stop5"});
        tx_data = 8'h55; tx_valid = 1'b1;
        do_accept("stop5");
        tx_valid = 1'b0;
        fork
            dev_frame(M_STOP5, "stop5", lf);
            wait_end("stop5", pc);
        join
        chk("timeout_latency", pc - lf, 2 + FLT + 1 + TMO);
        repeat (5) @(negedge clk);

        // 5. Reset at fall 6, then a clean 0xFF (parity 1)
        tx_data = 8'hA0; tx_valid = 1'b1;
        do_accept("rst6");
        tx_valid = 1'b0;
        dev_frame(M_RST6, "rst6", lf);
        @(negedge clk);
        chk("post_rst_idle",
            {26'd0, tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}, 32'b100000);
        ev_q.push_back('{1'b0, "ff"});
        fr_q.push_back('{8'hFF, 1'b1, "ff"});
        tx_data = CMD_RESET; tx_valid = 1'b1;
        do_accept("ff");
        tx_valid = 1'b0;
        fork
            dev_frame(M_NORMAL, "ff", lf);
            wait_end("ff", pc);
        join
        repeat (5) @(negedge clk);

        // 6. One-cycle clock glitch mid-frame: 0x5A, parity 1
        ev_q.push_back('{1'b0, "glitch"});
        fr_q.push_back('{8'h5A, 1'b1, "glitch"});
        tx_data = 8'h5A; tx_valid = 1'b1;
        do_accept("glitch");
        tx_valid = 1'b0;
        fork
            dev_frame(M_GLITCH, "glitch", lf);
            wait_end("glitch", pc);
        join
        repeat (20) @(negedge clk);

        chk("events_outstanding", ev_q.size(), 0);
        chk("frames_outstanding", fr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
